// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: fixed-latency MULT/DIV with a busy flag,
// plus single-edge MTHI/MTLO writes into the architectural HI/LO registers.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] resHi_q, resHi_d;
  logic [31:0] resLo_q, resLo_d;
  logic        divZero_q, divZero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prodSigned;
  logic [63:0] prodUnsigned;
  logic        divSigned;
  logic        negQuot;
  logic        negRem;
  logic [31:0] divA;
  logic [31:0] divB;
  logic [31:0] divBSafe;
  logic [31:0] quotMag;
  logic [31:0] remMag;
  logic [31:0] quot;
  logic [31:0] rem;

  logic        launch;
  logic [31:0] launchHi;
  logic [31:0] launchLo;
  logic [3:0]  launchCnt;
  logic        launchZero;

  // Full-width sign/zero extension keeps the low 64 product bits exact for both flavours.
  assign prodSigned   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prodUnsigned = {32'b0, a} * {32'b0, b};

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign divSigned = (op == OP_DIV);
  assign negRem    = divSigned & a[31];
  assign negQuot   = divSigned & (a[31] ^ b[31]);
  assign divA      = negRem ? (32'd0 - a) : a;
  assign divB      = (divSigned & b[31]) ? (32'd0 - b) : b;
  assign divBSafe  = (b == 32'd0) ? 32'd1 : divB;
  assign quotMag   = divA / divBSafe;
  assign remMag    = divA % divBSafe;
  assign quot      = negQuot ? (32'd0 - quotMag) : quotMag;
  assign rem       = negRem ? (32'd0 - remMag) : remMag;

  // A new multiply/divide may load in IDLE or on the commit edge of the previous one.
  assign launch = start && (op <= OP_DIVU) &&
                  ((state_q == IDLE) || (cnt_q == 4'd1));

  always_comb begin
    launchHi   = 32'd0;
    launchLo   = 32'd0;
    launchCnt  = MULT_N;
    launchZero = 1'b0;
    case (op)
      OP_MULT: begin
        launchHi = prodSigned[63:32];
        launchLo = prodSigned[31:0];
      end
      OP_MULTU: begin
        launchHi = prodUnsigned[63:32];
        launchLo = prodUnsigned[31:0];
      end
      OP_DIV, OP_DIVU: begin
        launchHi   = rem;
        launchLo   = quot;
        launchCnt  = DIV_N;
        launchZero = (b == 32'd0);
      end
      default: begin
        launchHi = 32'd0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resHi_d   = resHi_q;
    resLo_d   = resLo_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q == RUN) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        if (!divZero_q) begin
          hi_d = resHi_q;
          lo_d = resLo_q;
        end
      end
    end else if (start) begin
      if (op == OP_MTHI) begin
        hi_d = a;
      end
      if (op == OP_MTLO) begin
        lo_d = a;
      end
    end

    if (launch) begin
      state_d   = RUN;
      cnt_d     = launchCnt;
      resHi_d   = launchHi;
      resLo_d   = launchLo;
      divZero_d = launchZero;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      resHi_q   <= 32'd0;
      resLo_q   <= 32'd0;
      divZero_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      resHi_q   <= resHi_d;
      resLo_q   <= resLo_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed test-plan steps plus random ops against a 64-bit
// arithmetic reference model; a second instance covers the latency extremes.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        sBusy;
  logic [31:0] sHi;
  logic [31:0] sLo;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  always #5 clk = ~clk;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  mdu #(.MULT_CYCLES(1), .DIV_CYCLES(15)) dutSweep (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (sBusy),
    .hi    (sHi),
    .lo    (sLo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one op for exactly one rising edge; returns 1 time unit after that edge.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reference semantics in plain 64-bit arithmetic.
  task automatic modelOp(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    longint      sa;
    longint      sb;
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    sa = longint'($signed(aIn));
    sb = longint'($signed(bIn));
    case (opIn)
      3'd0: begin
        sp = sa * sb;
        modelHi = sp[63:32];
        modelLo = sp[31:0];
      end
      3'd1: begin
        up = 64'(aIn) * 64'(bIn);
        modelHi = up[63:32];
        modelLo = up[31:0];
      end
      3'd2: if (bIn != 32'd0) begin
        sq = sa / sb;
        sr = sa % sb;
        modelLo = sq[31:0];
        modelHi = sr[31:0];
      end
      3'd3: if (bIn != 32'd0) begin
        modelLo = aIn / bIn;
        modelHi = aIn % bIn;
      end
      3'd4: modelHi = aIn;
      3'd5: modelLo = aIn;
      default: ;
    endcase
  endtask

  task automatic runOp(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
    int w;
    int n;
    applyStimulus(opIn, aIn, bIn);
    modelOp(opIn, aIn, bIn);
    if (opIn <= 3'd3) begin
      n = (opIn < 3'd2) ? 5 : 10;
      w = 0;
      while (busy === 1'b1 && w < 40) begin
        w++;
        @(posedge clk);
        #1;
      end
      checkOutput("busyWidth", 32'(w), 32'(n));
    end else begin
      checkOutput("busyIdle", 32'(busy), 32'd0);
    end
    checkOutput("hi", hi, modelHi);
    checkOutput("lo", lo, modelLo);
  endtask

  initial begin
    int          w;
    logic [2:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    #12;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstHi", hi, 32'd0);
    checkOutput("rstLo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp(3'd0, 32'hFFFFFFFE, 32'd3);
    checkOutput("multHi", hi, 32'hFFFFFFFF);
    checkOutput("multLo", lo, 32'hFFFFFFFA);
    runOp(3'd1, 32'hFFFFFFFE, 32'd3);
    checkOutput("multuHi", hi, 32'h00000002);
    checkOutput("multuLo", lo, 32'hFFFFFFFA);
    runOp(3'd2, 32'hFFFFFFF9, 32'd2);
    checkOutput("divLo", lo, 32'hFFFFFFFD);
    checkOutput("divHi", hi, 32'hFFFFFFFF);
    runOp(3'd3, 32'd7, 32'd2);
    checkOutput("divuLo", lo, 32'd3);
    checkOutput("divuHi", hi, 32'd1);
    runOp(3'd4, 32'h12345678, 32'd0);
    checkOutput("mthi", hi, 32'h12345678);
    runOp(3'd5, 32'h9ABCDEF0, 32'd0);
    checkOutput("mtlo", lo, 32'h9ABCDEF0);
    runOp(3'd2, 32'd5, 32'd0);
    checkOutput("div0Hi", hi, 32'h12345678);
    checkOutput("div0Lo", lo, 32'h9ABCDEF0);

    // Overflow divide, an ignored MULT mid-run, then a MULT launched on the commit edge.
    applyStimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
    applyStimulus(3'd0, 32'd2, 32'd3);
    checkOutput("runBusy", 32'(busy), 32'd1);
    repeat (6) @(posedge clk);
    applyStimulus(3'd0, 32'd2, 32'd3);
    checkOutput("ovfHi", hi, 32'd0);
    checkOutput("ovfLo", lo, 32'h80000000);
    checkOutput("b2bBusy", 32'(busy), 32'd1);
    modelOp(3'd0, 32'd2, 32'd3);
    w = 0;
    while (busy === 1'b1 && w < 40) begin
      w++;
      @(posedge clk);
      #1;
    end
    checkOutput("b2bWidth", 32'(w), 32'd5);
    checkOutput("b2bLo", lo, 32'd6);
    checkOutput("b2bHi", hi, 32'd0);

    for (int i = 0; i < 24; i++) begin
      rOp = 3'($urandom_range(0, 7));
      rA  = $urandom;
      rB  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 5) begin
        rA = 32'h80000000;
        rB = 32'hFFFFFFFF;
      end
      runOp(rOp, rA, rB);
    end

    // Asynchronous reset in the middle of a multiply must clear everything with no late commit.
    runOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(3'd0, 32'd7, 32'd9);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortHi", hi, 32'd0);
    checkOutput("abortLo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("postBusy", 32'(busy), 32'd0);
    checkOutput("postHi", hi, 32'd0);
    checkOutput("postLo", lo, 32'd0);

    applyStimulus(3'd0, 32'd4, 32'd5);
    w = 0;
    while (sBusy === 1'b1 && w < 40) begin
      w++;
      @(posedge clk);
      #1;
    end
    checkOutput("sweepMultWidth", 32'(w), 32'd1);
    checkOutput("sweepMultLo", sLo, 32'd20);
    repeat (8) @(posedge clk);
    applyStimulus(3'd3, 32'd100, 32'd7);
    w = 0;
    while (sBusy === 1'b1 && w < 40) begin
      w++;
      @(posedge clk);
      #1;
    end
    checkOutput("sweepDivWidth", 32'(w), 32'd15);
    checkOutput("sweepDivLo", sLo, 32'd14);
    checkOutput("sweepDivHi", sHi, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS core, sitting in the E stage beside the ALU and feeding the HI/LO read path into the E/M pipeline register. It accepts `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` operations and models fixed multi-cycle latency with a busy flag. The hazard unit uses `busy` to stall any following MDU instruction in D; `mfhi`/`mflo` select `hi`/`lo` directly.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high for `mult`/`multu`. Legal range 1..15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high for `div`/`divu`. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  op valid this cycle; sampled on the rising edge.
- `op`  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are no-ops.
- `a`  in  32  rs operand; dividend; source for MTHI/MTLO.
- `b`  in  32  rt operand; divisor.
- `busy`  out  1  a multiply/divide is in flight.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- State machine with two states: IDLE and RUN. A 4-bit down-counter `cnt` and 32-bit `res_hi`/`res_lo` staging registers back it.
- In IDLE with `start` = 1:
  - `op` 0–3: compute the result at the sampling edge into `res_hi`/`res_lo`, load `cnt` with N (MULT_CYCLES or DIV_CYCLES), go to RUN.
  - `op` 4: HI <= a on that edge; stay in IDLE; `busy` never rises.
  - `op` 5: LO <= a on that edge; stay in IDLE; `busy` never rises.
  - `op` 6–7: ignored.
- In RUN, `cnt` decrements each edge. On the edge where `cnt` = 1:
  - HI <= res_hi and LO <= res_lo.
  - Go to IDLE.
- `start` while in RUN is ignored entirely, including MTHI/MTLO. The pipeline must stall such instructions; the block does not queue them.
- Arithmetic rules:
  - MULT: {HI,LO} = signed 32x32 product, 64-bit.
  - MULTU: {HI,LO} = unsigned 32x32 product, 64-bit.
  - DIV: LO = signed quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor 0 (DIV or DIVU): the op still takes DIV_CYCLES with `busy` high, but HI/LO are left unchanged at commit.
- `hi` and `lo` are driven directly from the registers and are never forwarded from the staging registers.

## Timing
- Reset (asserted low, asynchronous): `busy` = 0, `hi` = 0, `lo` = 0, state = IDLE, `cnt` = 0, staging registers = 0.
- Reset mid-RUN aborts the operation immediately. No commit occurs.
- `busy` is registered: `busy` = (state == RUN).
- Start sampled at edge k:
  - `busy` is high from k through k+N.
  - HI/LO show the new values from edge k+N.
  - `busy` is low after edge k+N.
  - The cycle containing edge k itself shows `busy` = 0. The hazard unit therefore stalls on `start | busy`.
- Back-to-back: a new `start` is accepted on edge k+N, the same edge as the commit. The old result commits and the new op loads into staging in that cycle.
- MTHI/MTLO latency is 1 edge. `hi`/`lo` are readable the next cycle.

## Test plan
- Reset, then MULT with a = 0xFFFFFFFE, b = 3 -> `busy` high 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU on the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV with a = 0xFFFFFFF9 (-7), b = 2 -> `busy` high 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with a = 7, b = 2 -> LO = 3, HI = 1.
- MTHI with a = 0x12345678, then MTLO with a = 0x9ABCDEF0 -> each visible after 1 edge; `busy` never rises. Next, DIV by b = 0 -> `busy` high 10 cycles; HI/LO still 0x12345678 / 0x9ABCDEF0.
- DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0. Then:
  - MULT 2*3 started during RUN is ignored.
  - MULT 2*3 started on the commit edge -> LO = 6 five cycles later.
- Start MULT, then pull `reset` low asynchronously at cycle 2 of RUN -> `busy`, `hi` and `lo` go to 0 immediately, with no commit after release.
- Parameter sweep with MULT_CYCLES = 1 and DIV_CYCLES = 15 -> `busy` pulse widths are exactly 1 and 15 cycles.
